// File: rtl/pdm_capture_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl_pkg
//   Shared definitions for the PDM microphone capture path:
//     - state_e      : controller state encoding (IDLE / WARMUP / CAPTURE)
//     - DEF_*        : default divider, window length and warm-up length
//     - sample_width : width of a ones-count sample able to hold 0..WINDOW
//     - cnt_width    : width of a counter running 0..n-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package pdm_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  // 100 MHz / 32 = 3.125 MHz microphone clock
  localparam int DEF_CLK_DIV     = 32;
  localparam int DEF_WINDOW      = 128;
  localparam int DEF_WARMUP_BITS = 1024;

  // One extra bit so an all-ones window (count == WINDOW) is representable.
  function automatic int sample_width(input int window);
    return $clog2(window) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pdm_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl_if
//   Valid/ready sample stream from the capture controller to the downstream
//   filter.
//     sample_o [SW] : ones-count of the last completed window
//     valid_o       : sample_o valid, held until accepted
//     ready_i       : consumer accepts when valid_o & ready_i
//   Modports: master (capture controller), slave (consumer).
// ---------------------------------------------------------------------------
interface pdm_capture_ctrl_if #(
  parameter int SW = 8
);
  logic [SW-1:0] sample_o;
  logic          valid_o;
  logic          ready_i;

  modport master (
    output sample_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  sample_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/pdm_capture_ctrl_mic_clk_strobe.sv
// ---------------------------------------------------------------------------
// mic_clk_strobe
//   Divides clk_i down to the microphone clock and marks its rising edges.
//   M_CLK is low for CLK_DIV/2 cycles, then high for CLK_DIV/2 cycles.
//   Ports:
//     clk_i    in  system clock
//     rst_i    in  asynchronous reset, active-high
//     run_i    in  1 = divider running; 0 = counter cleared, M_CLK low
//     M_CLK    out microphone clock (registered, glitch-free)
//     rise_stb out 1-cycle pulse during the first clk_i cycle M_CLK is high
// ---------------------------------------------------------------------------
module mic_clk_strobe
  import pdm_capture_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic M_CLK,
  output logic rise_stb
);

  localparam int CW   = cnt_width(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mclk_q, mclk_d;
  logic          rise_q, rise_d;

  // M_CLK and the strobe are decoded from the next counter value so both
  // come straight out of flops and line up on the same clk_i edge.
  always_comb begin
    cnt_d  = '0;
    mclk_d = 1'b0;
    rise_d = 1'b0;
    if (run_i) begin
      if (cnt_q == CW'(CLK_DIV - 1)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      mclk_d = (cnt_d >= CW'(HALF));
      rise_d = (cnt_d == CW'(HALF));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      mclk_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mclk_q <= mclk_d;
      rise_q <= rise_d;
    end
  end

  assign M_CLK    = mclk_q;
  assign rise_stb = rise_q;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl
//   Runs the on-board PDM microphone (gated M_CLK, M_LRSEL tied low,
//   warm-up), counts ones in M_DATA over windows of WINDOW bits and hands one
//   amplitude word per window to the downstream filter over valid/ready.
//   Ports:
//     clk_i       in  system clock
//     rst_i       in  asynchronous reset, active-high
//     enable_i    in  level; 1 = run microphone, 0 = stop (back to IDLE)
//     M_DATA      in  PDM data from the microphone
//     M_CLK       out microphone clock, 50% duty, low in IDLE
//     M_LRSEL     out channel select, constant 0
//     out_if      master modport: sample_o / valid_o / ready_i
//     busy_o      out 1 in WARMUP or CAPTURE
//     overrun_o   out sticky: a window completed while the previous sample
//                     was still unaccepted (new sample dropped)
//     drop_cnt_o  out 16-bit saturating dropped-sample count; present only
//                     when PDM_CAPTURE_DROP_CNT_EN is defined
//   Optional build macro: PDM_CAPTURE_DROP_CNT_EN
// ---------------------------------------------------------------------------
module pdm_capture_ctrl
  import pdm_capture_ctrl_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int WINDOW      = DEF_WINDOW,
  parameter int WARMUP_BITS = DEF_WARMUP_BITS
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      M_DATA,
  output logic                      M_CLK,
  output logic                      M_LRSEL,
  pdm_capture_ctrl_if.master        out_if,
`ifdef PDM_CAPTURE_DROP_CNT_EN
  output logic [15:0]               drop_cnt_o,
`endif
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int SW = sample_width(WINDOW);
  localparam int BW = cnt_width(WINDOW);
  localparam int WW = cnt_width(WARMUP_BITS);

  state_e        state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
`ifdef PDM_CAPTURE_DROP_CNT_EN
  logic [15:0]   drop_q, drop_d;
`endif

  logic run;
  logic rise_stb;
  logic accept;

  // Gating on enable_i as well as the state makes a disable stop M_CLK on
  // the same clk_i edge that returns the FSM to IDLE.
  assign run    = (state_q != ST_IDLE) && enable_i;
  assign accept = valid_q && out_if.ready_i;

  mic_clk_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_strobe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (run),
    .M_CLK    (M_CLK),
    .rise_stb (rise_stb)
  );

  // Next-state / datapath. M_DATA is taken on the clk_i edge at the end of
  // the rise_stb cycle; the accumulator (or the sample register on the last
  // bit) is the register that captures it.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    bit_d     = bit_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef PDM_CAPTURE_DROP_CNT_EN
    drop_d    = drop_q;
`endif

    if (!enable_i) begin
      // Stop from any state: partial window and pending sample are dropped.
      state_d   = ST_IDLE;
      warm_d    = '0;
      bit_d     = '0;
      acc_d     = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
`ifdef PDM_CAPTURE_DROP_CNT_EN
      drop_d    = '0;
`endif
    end else begin
      if (accept) begin
        valid_d = 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          state_d = ST_WARMUP;
          warm_d  = '0;
          bit_d   = '0;
          acc_d   = '0;
        end

        ST_WARMUP: begin
          if (rise_stb) begin
            if (warm_q == WW'(WARMUP_BITS - 1)) begin
              warm_d  = '0;
              state_d = ST_CAPTURE;
            end else begin
              warm_d = warm_q + 1'b1;
            end
          end
        end

        ST_CAPTURE: begin
          if (rise_stb) begin
            if (bit_q == BW'(WINDOW - 1)) begin
              // Window complete; next window starts with the next strobe.
              bit_d = '0;
              acc_d = '0;
              if (!valid_q || accept) begin
                sample_d = acc_q + SW'(M_DATA);
                valid_d  = 1'b1;
              end else begin
                overrun_d = 1'b1;
`ifdef PDM_CAPTURE_DROP_CNT_EN
                if (drop_q != 16'hFFFF) begin
                  drop_d = drop_q + 16'd1;
                end
`endif
              end
            end else begin
              bit_d = bit_q + 1'b1;
              acc_d = acc_q + SW'(M_DATA);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      warm_q    <= '0;
      bit_q     <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PDM_CAPTURE_DROP_CNT_EN
      drop_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      bit_q     <= bit_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef PDM_CAPTURE_DROP_CNT_EN
      drop_q    <= drop_d;
`endif
    end
  end

  assign out_if.sample_o = sample_q;
  assign out_if.valid_o  = valid_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign overrun_o       = overrun_q;
  assign M_LRSEL         = 1'b0;
`ifdef PDM_CAPTURE_DROP_CNT_EN
  assign drop_cnt_o      = drop_q;
`endif

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
`timescale 1ns/1ps
module tb_pdm_capture_ctrl;
  import pdm_capture_ctrl_pkg::*;

  localparam int CLK_DIV     = 4;
  localparam int WINDOW      = 8;
  localparam int WARMUP_BITS = 4;
  localparam int SW          = $clog2(WINDOW) + 1;
  localparam int FIRST_RISE  = WARMUP_BITS + WINDOW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic m_data = 1'b0;
  logic m_clk, m_lrsel, busy, overrun;
`ifdef PDM_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  pdm_capture_ctrl_if #(.SW(SW)) out_if ();

  pdm_capture_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .WINDOW      (WINDOW),
    .WARMUP_BITS (WARMUP_BITS)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .M_DATA     (m_data),
    .M_CLK      (m_clk),
    .M_LRSEL    (m_lrsel),
    .out_if     (out_if),
`ifdef PDM_CAPTURE_DROP_CNT_EN
    .drop_cnt_o (drop_cnt),
`endif
    .busy_o     (busy),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Microphone model and scoreboard. Data changes on M_CLK falling edges;
  // on each M_CLK rising edge the model counts the bit and, once warm-up is
  // over, sums it into the current window and queues the expected sample.
  int pat_mode = 0;   // 0 zeros, 1 ones, 2 alternating, 3 random
  int rise_n = 0;
  int wbits = 0;
  int wsum = 0;
  logic [SW-1:0] exp_q[$];

  always @(negedge m_clk) begin
    case (pat_mode)
      0: m_data = 1'b0;
      1: m_data = 1'b1;
      2: m_data = ~m_data;
      default: m_data = 1'($urandom_range(0, 1));
    endcase
  end

  always @(posedge m_clk) begin
    rise_n = rise_n + 1;
    if (rise_n > WARMUP_BITS) begin
      wsum  = wsum + int'(m_data);
      wbits = wbits + 1;
      if (wbits == WINDOW) begin
        exp_q.push_back(SW'(wsum));
        wsum  = 0;
        wbits = 0;
      end
    end
  end

  task automatic model_clear();
    rise_n = 0;
    wbits  = 0;
    wsum   = 0;
    exp_q.delete();
  endtask

  task automatic stop_run();
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_clear();
  endtask

  task automatic test_reset();
    logic [SW-1:0] zero_s;
    zero_s = '0;
    rst = 1'b1;
    enable = 1'b0;
    out_if.ready_i = 1'b0;
    #2;
    checks++;
    if (m_clk !== 1'b0 || out_if.valid_o !== 1'b0 || busy !== 1'b0 || out_if.sample_o !== zero_s) begin
      errors++;
      $display("FAIL reset_asserted: m_clk=%b valid=%b busy=%b sample=%0d, required 0 0 0 0",
               m_clk, out_if.valid_o, busy, out_if.sample_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (m_clk !== 1'b0 || out_if.valid_o !== 1'b0 || busy !== 1'b0 || m_lrsel !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: m_clk=%b valid=%b busy=%b lrsel=%b, required all 0",
                 i, m_clk, out_if.valid_o, busy, m_lrsel);
      end
    end
    checks++;
    if (out_if.sample_o !== zero_s || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: sample=%0d overrun=%b, required 0 0", out_if.sample_o, overrun);
    end
`ifdef PDM_CAPTURE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_ones_latency();
    int n;
    logic [SW-1:0] e;
    pat_mode = 1;
    m_data = 1'b1;
    out_if.ready_i = 1'b1;
    model_clear();
    @(negedge clk) enable = 1'b1;
    n = 0;
    while (rise_n < FIRST_RISE && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rise_n != FIRST_RISE || out_if.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ones_pre_valid: rise_n=%0d valid=%b, required %0d 0", rise_n, out_if.valid_o, FIRST_RISE);
    end
    @(negedge clk);
    checks++;
    if (out_if.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL ones_first_valid: valid=%b, required 1 one cycle after strobe %0d", out_if.valid_o, FIRST_RISE);
    end
    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (out_if.valid_o !== 1'b1 && n < 100);
        checks++;
        if (n != CLK_DIV * WINDOW) begin
          errors++;
          $display("FAIL ones_interval sample %0d: got %0d cycles, required %0d", s, n, CLK_DIV * WINDOW);
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ones_scoreboard sample %0d: got value %0d with no expected entry", s, out_if.sample_o);
      end else begin
        e = exp_q.pop_front();
        $display("ones sample %0d accepted value=%0d expected=%0d", s, out_if.sample_o, e);
        if (out_if.sample_o !== e || out_if.sample_o !== SW'(WINDOW)) begin
          errors++;
          $display("FAIL ones_sample %0d: got %0d, required %0d", s, out_if.sample_o, WINDOW);
        end
      end
    end
    stop_run();
  endtask

  task automatic test_alternating();
    int n;
    logic [SW-1:0] e;
    pat_mode = 2;
    m_data = 1'b1;
    out_if.ready_i = 1'b1;
    model_clear();
    @(negedge clk) enable = 1'b1;
    n = 0;
    while (rise_n < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int p = 0; p < 2; p++) begin
      int target;
      target = rise_n + 1;
      n = 0;
      while (rise_n < target && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != CLK_DIV) begin
        errors++;
        $display("FAIL alt_mclk_period %0d: got %0d cycles, required %0d", p, n, CLK_DIV);
      end
    end
    for (int s = 0; s < 3; s++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (out_if.valid_o !== 1'b1 && n < 200);
      checks++;
      if (n >= 200 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL alt_wait sample %0d: valid=%b queued=%0d, required a valid sample", s, out_if.valid_o, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        $display("alt sample %0d accepted value=%0d expected=%0d", s, out_if.sample_o, e);
        if (out_if.sample_o !== e || out_if.sample_o !== SW'(WINDOW / 2)) begin
          errors++;
          $display("FAIL alt_sample %0d: got %0d, required %0d", s, out_if.sample_o, WINDOW / 2);
        end
      end
    end
    stop_run();
  endtask

  task automatic test_overrun();
    int n;
    logic [SW-1:0] e;
    pat_mode = 3;
    m_data = 1'b0;
    out_if.ready_i = 1'b0;
    model_clear();
    @(negedge clk) enable = 1'b1;
    n = 0;
    while (exp_q.size() < 1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 1 || out_if.valid_o !== 1'b1 || overrun !== 1'b0 || out_if.sample_o !== exp_q[0]) begin
      errors++;
      $display("FAIL ovr_first_held: valid=%b overrun=%b sample=%0d, required 1 0 %0d",
               out_if.valid_o, overrun, out_if.sample_o, (exp_q.size() > 0) ? int'(exp_q[0]) : -1);
    end
    n = 0;
    while (exp_q.size() < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 2 || out_if.valid_o !== 1'b1 || overrun !== 1'b1 || out_if.sample_o !== exp_q[0]) begin
      errors++;
      $display("FAIL ovr_second_dropped: queued=%0d valid=%b overrun=%b sample=%0d, required 2 1 1 %0d",
               exp_q.size(), out_if.valid_o, overrun, out_if.sample_o, (exp_q.size() > 0) ? int'(exp_q[0]) : -1);
    end
`ifdef PDM_CAPTURE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ovr_drop_cnt: got %0d, required 1", drop_cnt);
    end
`endif
    if (exp_q.size() == 2) begin
      exp_q.delete(1);
    end
    @(negedge clk) out_if.ready_i = 1'b1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("ovr sample accepted value=%0d expected=%0d", out_if.sample_o, e);
    end
    @(negedge clk) out_if.ready_i = 1'b0;
    checks++;
    if (out_if.valid_o !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_after_accept: valid=%b overrun=%b, required 0 1", out_if.valid_o, overrun);
    end
    stop_run();
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_cleared_on_disable: overrun=%b busy=%b, required 0 0", overrun, busy);
    end
`ifdef PDM_CAPTURE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ovr_drop_cnt_cleared: got %0d, required 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_disable_midwindow();
    int n;
    logic [SW-1:0] e;
    pat_mode = 1;
    m_data = 1'b1;
    out_if.ready_i = 1'b1;
    model_clear();
    @(negedge clk) enable = 1'b1;
    n = 0;
    while (rise_n < WARMUP_BITS + 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    pat_mode = 0;
    m_data = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_clk !== 1'b0 || out_if.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL dis_stopped: busy=%b m_clk=%b valid=%b, required 0 0 0", busy, m_clk, out_if.valid_o);
    end
    model_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_if.valid_o !== 1'b0 || m_clk !== 1'b0) begin
        errors++;
        $display("FAIL dis_idle cycle %0d: valid=%b m_clk=%b, required 0 0", i, out_if.valid_o, m_clk);
      end
    end
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_if.valid_o !== 1'b1 && n < 400);
    checks++;
    if (n >= 400 || rise_n != FIRST_RISE || exp_q.size() == 0) begin
      errors++;
      $display("FAIL dis_rewarm: valid=%b after %0d rises, required first sample after %0d rises",
               out_if.valid_o, rise_n, FIRST_RISE);
    end else begin
      e = exp_q.pop_front();
      $display("dis sample accepted value=%0d expected=%0d", out_if.sample_o, e);
      if (out_if.sample_o !== e) begin
        errors++;
        $display("FAIL dis_sample: got %0d, required %0d", out_if.sample_o, e);
      end
    end
    stop_run();
  endtask

  task automatic test_async_reset();
    int n;
    logic [SW-1:0] zero_s;
    zero_s = '0;
    pat_mode = 3;
    out_if.ready_i = 1'b0;
    model_clear();
    @(negedge clk) enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_if.valid_o !== 1'b1 && n < 400);
    checks++;
    if (out_if.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup: valid=%b, required 1 before reset", out_if.valid_o);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_clk !== 1'b0 || out_if.valid_o !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
        out_if.sample_o !== zero_s) begin
      errors++;
      $display("FAIL arst_immediate: m_clk=%b valid=%b busy=%b overrun=%b sample=%0d, required all 0",
               m_clk, out_if.valid_o, busy, overrun, out_if.sample_o);
    end
    enable = 1'b0;
    @(negedge clk) rst = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_if.valid_o !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL arst_after cycle %0d: valid=%b busy=%b, required 0 0", i, out_if.valid_o, busy);
      end
    end
  endtask

  initial begin
    out_if.ready_i = 1'b0;
    test_reset();
    test_ones_latency();
    test_alternating();
    test_overrun();
    test_disable_midwindow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
